// File: rtl/vc_traffic_gen_if.sv
// Request/grant/flit bundle between vc_traffic_gen (master) and an arbiter or bench (slave).
// Per-VC statistics outputs exist only when VC_TRAFFIC_STATS_EN is defined.
interface vc_traffic_gen_if #(
    parameter int vc_num     = 3,
    parameter int prio_num   = 2,
    parameter int output_num = 8,
    parameter int len_w      = 6
);
    localparam int N  = vc_num * prio_num;
    localparam int VW = (N > 1) ? $clog2(N) : 1;

    logic                             enable;
    logic [15:0]                      inject_thresh;
    logic [len_w-1:0]                 len_min;
    logic [len_w-1:0]                 len_max;
    logic                             fixed_vcs_enable;
    logic [N-1:0]                     fixed_vcs;
    logic                             cts;
    logic [VW-1:0]                    selected_vc;
    logic                             ready;

    logic [N-1:0]                     o_has_packet;
    logic [N-1:0][output_num-1:0]     dest_o;
    logic [N-1:0][VW-1:0]             output_vc_o;
    logic                             o_valid;
    logic                             o_last;
    logic [VW-1:0]                    o_vc;

`ifdef VC_TRAFFIC_STATS_EN
    logic [N-1:0][31:0]               pkt_count_o;
    logic [31:0]                      flit_count_o;

    modport master (
        input  enable, inject_thresh, len_min, len_max, fixed_vcs_enable, fixed_vcs,
               cts, selected_vc, ready,
        output o_has_packet, dest_o, output_vc_o, o_valid, o_last, o_vc,
               pkt_count_o, flit_count_o
    );

    modport slave (
        output enable, inject_thresh, len_min, len_max, fixed_vcs_enable, fixed_vcs,
               cts, selected_vc, ready,
        input  o_has_packet, dest_o, output_vc_o, o_valid, o_last, o_vc,
               pkt_count_o, flit_count_o
    );
`else
    modport master (
        input  enable, inject_thresh, len_min, len_max, fixed_vcs_enable, fixed_vcs,
               cts, selected_vc, ready,
        output o_has_packet, dest_o, output_vc_o, o_valid, o_last, o_vc
    );

    modport slave (
        output enable, inject_thresh, len_min, len_max, fixed_vcs_enable, fixed_vcs,
               cts, selected_vc, ready,
        input  o_has_packet, dest_o, output_vc_o, o_valid, o_last, o_vc
    );
`endif
endinterface

// File: rtl/vc_traffic_gen.sv
// Per-VC packet source: seeded Galois LFSRs drive request, destination, output VC and length.
// Define VC_TRAFFIC_STATS_EN to add per-VC packet counters and a total accepted-flit counter.
module vc_traffic_gen #(
    parameter int          vc_num     = 3,
    parameter int          prio_num   = 2,
    parameter int          output_num = 8,
    parameter int          len_w      = 6,
    parameter int          gap_cycles = 2,
    parameter logic [15:0] seed       = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    vc_traffic_gen_if.master bus
);
    localparam int N  = vc_num * prio_num;
    localparam int VW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
    localparam logic [GW-1:0] GAP_LAST = (gap_cycles > 0) ? GW'(gap_cycles - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND, S_GAP} state_t;

    // Shared flit datapath: only one VC can own it at a time.
    logic             r_busy;
    logic             r_valid;
    logic             r_last;
    logic [VW-1:0]    r_vc;
    logic [len_w-1:0] r_count;

    logic [len_w-1:0] w_lo;
    logic [len_w-1:0] w_hi;
    logic [len_w:0]   w_span;
    logic [N-1:0]     w_req;
    logic [N-1:0][len_w-1:0] w_len;
    logic             w_sel_ok;
    logic             w_grant;
    logic             w_done;
    logic             w_beat;
    logic [len_w-1:0] w_len_sel;

    assign w_lo   = (bus.len_min == '0) ? len_w'(1) : bus.len_min;
    assign w_hi   = (bus.len_max < w_lo) ? w_lo : bus.len_max;
    assign w_span = {1'b0, w_hi} - {1'b0, w_lo} + (len_w+1)'(1);

    assign w_sel_ok  = ({1'b0, bus.selected_vc} < (VW+1)'(N));
    assign w_grant   = bus.cts && !r_busy && w_sel_ok && w_req[bus.selected_vc];
    assign w_len_sel = w_len[bus.selected_vc];
    assign w_beat    = r_valid && bus.ready;
    assign w_done    = w_beat && r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_vc    <= '0;
            r_count <= '0;
        end else if (w_grant) begin
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_vc    <= bus.selected_vc;
            r_count <= w_len_sel;
            r_last  <= (w_len_sel == len_w'(1));
        end else if (w_beat) begin
            if (r_last) begin
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_count <= '0;
            end else begin
                r_count <= r_count - len_w'(1);
                r_last  <= (r_count == len_w'(2));
            end
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_last  = r_last;
    assign bus.o_vc    = r_vc;

    for (genvar gi = 0; gi < N; gi++) begin : g_vc
        localparam logic [15:0]   SEED_X = seed ^ 16'(gi + 1);
        localparam logic [15:0]   SEED_I = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;
        localparam logic [VW-1:0] VC_ID  = VW'(gi);

        state_t                r_state;
        logic [15:0]           r_lfsr;
        logic                  r_has;
        logic [output_num-1:0] r_dest;
        logic [VW-1:0]         r_ovc;
        logic [len_w-1:0]      r_len;
        logic [GW-1:0]         r_gap;
        logic                  w_want;
        logic                  w_mine;

        assign w_want = bus.enable &&
                        (bus.fixed_vcs_enable ? bus.fixed_vcs[gi]
                                              : (r_lfsr < bus.inject_thresh));
        assign w_mine = (r_vc == VC_ID);

        // Galois form of x^16+x^14+x^13+x^11+1, free-running.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_lfsr <= SEED_I;
            end else begin
                r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= S_IDLE;
                r_has   <= 1'b0;
                r_dest  <= '0;
                r_ovc   <= '0;
                r_len   <= '0;
                r_gap   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_want) begin
                            r_state <= S_REQ;
                            r_has   <= 1'b1;
                            r_dest  <= output_num'(1) << (int'(r_lfsr[15:8]) % output_num);
                            r_ovc   <= bus.fixed_vcs_enable ? VC_ID
                                                            : VW'(int'(r_lfsr[7:0]) % N);
                            r_len   <= w_lo + len_w'({1'b0, r_lfsr[len_w-1:0]} % w_span);
                        end
                    end
                    S_REQ: begin
                        if (w_grant && (bus.selected_vc == VC_ID)) begin
                            r_state <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        if (w_done && w_mine) begin
                            r_state <= (gap_cycles == 0) ? S_IDLE : S_GAP;
                            r_has   <= 1'b0;
                            r_gap   <= '0;
                        end
                    end
                    S_GAP: begin
                        if (r_gap == GAP_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gap <= r_gap + GW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

        assign w_req[gi]            = (r_state == S_REQ);
        assign w_len[gi]            = r_len;
        assign bus.o_has_packet[gi] = r_has;
        assign bus.dest_o[gi]       = r_dest;
        assign bus.output_vc_o[gi]  = r_ovc;

`ifdef VC_TRAFFIC_STATS_EN
        logic [31:0] r_pkt_count;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_pkt_count <= '0;
            end else if (w_done && w_mine) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end

        assign bus.pkt_count_o[gi] = r_pkt_count;
`endif
    end

`ifdef VC_TRAFFIC_STATS_EN
    logic [31:0] r_flit_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flit_count <= '0;
        end else if (w_beat) begin
            r_flit_count <= r_flit_count + 32'd1;
        end
    end

    assign bus.flit_count_o = r_flit_count;
`endif
endmodule

// File: tb/tb_vc_traffic_gen.sv
// Self-checking bench for vc_traffic_gen: randomized lengths, ready stalls and injection
// settings checked against expectations computed from the packet rules.
module tb_vc_traffic_gen;
    localparam int VCN = 3;
    localparam int PRN = 2;
    localparam int N   = VCN * PRN;
    localparam int ON  = 8;
    localparam int LW  = 6;
    localparam int GAP = 2;
    localparam int VW  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    vc_traffic_gen_if #(.vc_num(VCN), .prio_num(PRN), .output_num(ON), .len_w(LW)) bus ();

    vc_traffic_gen #(
        .vc_num(VCN), .prio_num(PRN), .output_num(ON), .len_w(LW),
        .gap_cycles(GAP), .seed(16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.cts = 1'b0;
        bus.selected_vc = '0;
        bus.ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic wait_req(input int v, output bit ok);
        int guard;
        guard = 0;
        while (!bus.o_has_packet[v] && guard < 200) begin
            tick();
            guard++;
        end
        ok = bus.o_has_packet[v];
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        bus.inject_thresh = 16'hFFFF;
        bus.len_min = 6'd1;
        bus.len_max = 6'd4;
        bus.fixed_vcs_enable = 1'b0;
        bus.fixed_vcs = '0;
        reset = 1'b1;
        bus.cts = 1'b0;
        bus.ready = 1'b1;
        bus.selected_vc = '0;
        repeat (3) tick();
        tests++;
        if ({bus.o_has_packet, bus.o_valid, bus.o_last, bus.o_vc} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: got has=%b valid=%b last=%b vc=%0d expected all 0",
                     bus.o_has_packet, bus.o_valid, bus.o_last, bus.o_vc);
        end
        tests++;
        if ({bus.dest_o, bus.output_vc_o} !== '0) begin
            fails++;
            $display("FAIL reset_fields: got dest=%h ovc=%h expected 0", bus.dest_o, bus.output_vc_o);
        end
        reset = 1'b0;
        repeat (2) tick();
        tests++;
        if (bus.o_has_packet !== {N{1'b1}}) begin
            fails++;
            $display("FAIL reset_rise: got has=%b expected %b", bus.o_has_packet, {N{1'b1}});
        end
        for (int v = 0; v < N; v++) begin
            tests++;
            if (!$onehot(bus.dest_o[v]) || int'(bus.output_vc_o[v]) >= N) begin
                fails++;
                $display("FAIL reset_latch: vc %0d got dest=%b ovc=%0d expected one-hot and <%0d",
                         v, bus.dest_o[v], bus.output_vc_o[v], N);
            end
        end
    endtask

    task automatic test_fixed_packets();
        bit ok;
        bit rdy;
        int lowc;
        int v;
        int len;
        int rem;
        int cyc;
        logic [N-1:0] m;
        bus.enable = 1'b1;
        bus.fixed_vcs_enable = 1'b1;
        bus.fixed_vcs = 6'b000100;
        bus.len_min = 6'd4;
        bus.len_max = 6'd4;
        apply_reset();
        wait_req(2, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL fixed_req: got no request on vc 2 expected one"); end
        tests++;
        if (bus.output_vc_o[2] !== 3'd2) begin
            fails++;
            $display("FAIL fixed_ovc: got %0d expected 2", bus.output_vc_o[2]);
        end
        bus.cts = 1'b1;
        bus.selected_vc = 3'd2;
        tick();
        bus.cts = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_vc !== 3'd2 || bus.o_last !== (b == 4)) begin
                fails++;
                $display("FAIL fixed_beat%0d: got valid=%b vc=%0d last=%b expected 1/2/%b",
                         b, bus.o_valid, bus.o_vc, bus.o_last, (b == 4));
            end
            tick();
        end
        tests++;
        if (bus.o_valid !== 1'b0) begin
            fails++;
            $display("FAIL fixed_end: got valid=%b expected 0", bus.o_valid);
        end
        lowc = 0;
        while (!bus.o_has_packet[2] && lowc < 50) begin
            lowc++;
            tick();
        end
        tests++;
        if (lowc != GAP + 1) begin
            fails++;
            $display("FAIL fixed_gap: got %0d idle cycles expected %0d", lowc, GAP + 1);
        end
        $display("[TB] fixed pkt vc=2 len=4 re-request after %0d cycles", lowc);

        for (int p = 0; p < 8; p++) begin
            v = $urandom_range(0, N - 1);
            len = $urandom_range(1, 9);
            m = '0;
            m[v] = 1'b1;
            bus.fixed_vcs = m;
            bus.len_min = LW'(len);
            bus.len_max = LW'(len);
            apply_reset();
            wait_req(v, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL rnd_req: got no request on vc %0d", v); end
            tests++;
            if (int'(bus.output_vc_o[v]) != v) begin
                fails++;
                $display("FAIL rnd_ovc: got %0d expected %0d", bus.output_vc_o[v], v);
            end
            bus.cts = 1'b1;
            bus.selected_vc = VW'(v);
            tick();
            bus.cts = 1'b0;
            rem = len;
            cyc = 0;
            while (rem > 0 && cyc < 200) begin
                tests++;
                if (bus.o_valid !== 1'b1 || int'(bus.o_vc) != v || bus.o_last !== (rem == 1)) begin
                    fails++;
                    $display("FAIL rnd_beat: pkt %0d rem %0d got valid=%b vc=%0d last=%b expected 1/%0d/%b",
                             p, rem, bus.o_valid, bus.o_vc, bus.o_last, v, (rem == 1));
                end
                rdy = 1'($urandom_range(0, 1));
                bus.ready = rdy;
                tick();
                cyc++;
                if (rdy) rem--;
            end
            bus.ready = 1'b1;
            tests++;
            if (bus.o_valid !== 1'b0 || bus.o_has_packet[v] !== 1'b0) begin
                fails++;
                $display("FAIL rnd_end: got valid=%b has=%b expected 0/0", bus.o_valid, bus.o_has_packet[v]);
            end
            $display("[TB] rnd pkt vc=%0d len=%0d cycles=%0d", v, len, cyc);
        end
    endtask

    task automatic test_back_to_back();
        bit ok2;
        bit ok3;
        bus.enable = 1'b1;
        bus.fixed_vcs_enable = 1'b1;
        bus.fixed_vcs = 6'b001100;
        bus.len_min = 6'd4;
        bus.len_max = 6'd4;
        apply_reset();
        wait_req(2, ok2);
        wait_req(3, ok3);
        tests++;
        if (!(ok2 && ok3)) begin
            fails++;
            $display("FAIL b2b_req: got has=%b expected vc2 and vc3 set", bus.o_has_packet);
        end
        bus.cts = 1'b1;
        bus.selected_vc = 3'd2;
        tick();
        for (int b = 1; b <= 4; b++) begin
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_vc !== 3'd2 || bus.o_last !== (b == 4) ||
                bus.o_has_packet[3] !== 1'b1) begin
                fails++;
                $display("FAIL b2b_vc2_beat%0d: got valid=%b vc=%0d last=%b has3=%b expected 1/2/%b/1",
                         b, bus.o_valid, bus.o_vc, bus.o_last, bus.o_has_packet[3], (b == 4));
            end
            bus.cts = (b == 1);
            bus.selected_vc = 3'd3;
            tick();
        end
        tests++;
        if (bus.o_valid !== 1'b0 || bus.o_has_packet[3] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_gap: got valid=%b has3=%b expected 0/1", bus.o_valid, bus.o_has_packet[3]);
        end
        bus.cts = 1'b1;
        bus.selected_vc = 3'd5;
        tick();
        tests++;
        if (bus.o_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_notreq: got valid=%b expected 0 for cts to idle vc 5", bus.o_valid);
        end
        bus.selected_vc = 3'd3;
        tick();
        bus.cts = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_vc !== 3'd3 || bus.o_last !== (b == 4)) begin
                fails++;
                $display("FAIL b2b_vc3_beat%0d: got valid=%b vc=%0d last=%b expected 1/3/%b",
                         b, bus.o_valid, bus.o_vc, bus.o_last, (b == 4));
            end
            tick();
        end
        $display("[TB] b2b vc2 then vc3 len=4");
    endtask

    task automatic test_len1_stall();
        bit ok;
        bus.enable = 1'b1;
        bus.fixed_vcs_enable = 1'b1;
        bus.fixed_vcs = 6'b000001;
        bus.len_min = 6'd1;
        bus.len_max = 6'd1;
        apply_reset();
        wait_req(0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL len1_req: got no request on vc 0"); end
        bus.ready = 1'b0;
        bus.cts = 1'b1;
        bus.selected_vc = 3'd0;
        tick();
        bus.cts = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_last !== 1'b1 || bus.o_vc !== 3'd0) begin
                fails++;
                $display("FAIL len1_hold%0d: got valid=%b last=%b vc=%0d expected 1/1/0",
                         k, bus.o_valid, bus.o_last, bus.o_vc);
            end
            bus.ready = (k == 3);
            tick();
        end
        tests++;
        if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0) begin
            fails++;
            $display("FAIL len1_done: got valid=%b last=%b expected 0/0", bus.o_valid, bus.o_last);
        end
        bus.ready = 1'b1;
        $display("[TB] len1 pkt vc=0 stalled 3 cycles");
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit rdy;
        int rem;
        int cyc;
        int bad;
        bus.enable = 1'b1;
        bus.fixed_vcs_enable = 1'b1;
        bus.fixed_vcs = 6'b000010;
        bus.len_min = 6'd5;
        bus.len_max = 6'd5;
        apply_reset();
        wait_req(1, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL endrop_req: got no request on vc 1"); end
        bus.cts = 1'b1;
        bus.selected_vc = 3'd1;
        tick();
        bus.cts = 1'b0;
        rem = 5;
        cyc = 0;
        while (rem > 0 && cyc < 100) begin
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_vc !== 3'd1 || bus.o_last !== (rem == 1)) begin
                fails++;
                $display("FAIL endrop_beat: rem %0d got valid=%b vc=%0d last=%b expected 1/1/%b",
                         rem, bus.o_valid, bus.o_vc, bus.o_last, (rem == 1));
            end
            if (cyc == 1) bus.enable = 1'b0;
            rdy = 1'($urandom_range(0, 1));
            bus.ready = rdy;
            tick();
            cyc++;
            if (rdy) rem--;
        end
        bus.ready = 1'b1;
        bad = 0;
        repeat (30) begin
            if (bus.o_has_packet !== '0 || bus.o_valid !== 1'b0) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL endrop_quiet: got %0d cycles with activity expected 0", bad);
        end
        bus.enable = 1'b1;
        $display("[TB] enable-drop pkt vc=1 len=5 cycles=%0d", cyc);
    endtask

    task automatic test_no_inject();
        int bad;
        bus.enable = 1'b1;
        bus.fixed_vcs_enable = 1'b0;
        bus.inject_thresh = 16'h0000;
        apply_reset();
        bad = 0;
        repeat (1000) begin
            tick();
            if (bus.o_has_packet !== '0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL noinject: got %0d cycles with requests expected 0", bad);
        end
        $display("[TB] thresh=0 idle 1000 cycles");
    endtask

    task automatic test_random_inject();
        int lmin;
        int lmax;
        int lo;
        int hi;
        int v;
        int guard;
        int beats;
        int cyc;
        bit done;
        bit rdy;
        bit was_last;
        logic [ON-1:0] d0;
        logic [VW-1:0] ovc0;
        bus.enable = 1'b1;
        bus.fixed_vcs_enable = 1'b0;
        for (int p = 0; p < 6; p++) begin
            bus.inject_thresh = 16'($urandom_range(16'h4000, 16'hFFFF));
            lmin = $urandom_range(0, 12);
            lmax = $urandom_range(0, 12);
            lo = (lmin == 0) ? 1 : lmin;
            hi = (lmax < lo) ? lo : lmax;
            bus.len_min = LW'(lmin);
            bus.len_max = LW'(lmax);
            apply_reset();
            guard = 0;
            while (bus.o_has_packet == '0 && guard < 200) begin
                tick();
                guard++;
            end
            tests++;
            if (bus.o_has_packet == '0) begin
                fails++;
                $display("FAIL rinj_req: got no request within 200 cycles expected one");
            end
            v = 0;
            for (int k = N - 1; k >= 0; k--) if (bus.o_has_packet[k]) v = k;
            d0 = bus.dest_o[v];
            ovc0 = bus.output_vc_o[v];
            tests++;
            if (!$onehot(d0) || int'(ovc0) >= N) begin
                fails++;
                $display("FAIL rinj_fields: vc %0d got dest=%b ovc=%0d expected one-hot and <%0d",
                         v, d0, ovc0, N);
            end
            bus.cts = 1'b1;
            bus.selected_vc = VW'(v);
            tick();
            bus.cts = 1'b0;
            beats = 0;
            cyc = 0;
            done = 1'b0;
            while (!done && cyc < 300) begin
                tests++;
                if (bus.o_valid !== 1'b1 || int'(bus.o_vc) != v ||
                    bus.dest_o[v] !== d0 || bus.output_vc_o[v] !== ovc0) begin
                    fails++;
                    $display("FAIL rinj_beat: vc %0d got valid=%b vc=%0d dest=%b ovc=%0d expected 1/%0d/%b/%0d",
                             v, bus.o_valid, bus.o_vc, bus.dest_o[v], bus.output_vc_o[v], v, d0, ovc0);
                    break;
                end
                was_last = bus.o_last;
                rdy = 1'($urandom_range(0, 1));
                bus.ready = rdy;
                tick();
                cyc++;
                if (rdy) begin
                    beats++;
                    if (was_last) done = 1'b1;
                end
            end
            bus.ready = 1'b1;
            tests++;
            if (!done || beats < lo || beats > hi) begin
                fails++;
                $display("FAIL rinj_len: got %0d beats (done=%b) expected %0d..%0d", beats, done, lo, hi);
            end
            $display("[TB] rinj pkt vc=%0d len=%0d range=%0d..%0d", v, beats, lo, hi);
        end
    endtask

`ifdef VC_TRAFFIC_STATS_EN
    task automatic test_stats();
        bit ok;
        int missed;
        bus.enable = 1'b1;
        bus.fixed_vcs_enable = 1'b1;
        bus.fixed_vcs = 6'b000001;
        bus.len_min = 6'd3;
        bus.len_max = 6'd3;
        apply_reset();
        missed = 0;
        for (int p = 0; p < 10; p++) begin
            wait_req(0, ok);
            if (!ok) missed++;
            bus.cts = 1'b1;
            bus.selected_vc = 3'd0;
            tick();
            bus.cts = 1'b0;
            repeat (3) tick();
        end
        tick();
        tests++;
        if (missed != 0) begin
            fails++;
            $display("FAIL stats_req: got %0d missing requests expected 0", missed);
        end
        tests++;
        if (bus.pkt_count_o[0] !== 32'd10 || bus.pkt_count_o[1] !== 32'd0) begin
            fails++;
            $display("FAIL stats_pkt: got vc0=%0d vc1=%0d expected 10/0", bus.pkt_count_o[0], bus.pkt_count_o[1]);
        end
        tests++;
        if (bus.flit_count_o !== 32'd30) begin
            fails++;
            $display("FAIL stats_flit: got %0d expected 30", bus.flit_count_o);
        end
        $display("[TB] stats 10 pkts len=3 on vc0");
    endtask
`endif

    initial begin
        bus.enable = 1'b0;
        bus.inject_thresh = 16'h0000;
        bus.len_min = '0;
        bus.len_max = '0;
        bus.fixed_vcs_enable = 1'b0;
        bus.fixed_vcs = '0;
        bus.cts = 1'b0;
        bus.selected_vc = '0;
        bus.ready = 1'b1;
        test_reset();
        test_fixed_packets();
        test_back_to_back();
        test_len1_stall();
        test_enable_drop();
        test_no_inject();
        test_random_inject();
`ifdef VC_TRAFFIC_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
